// File: rtl/tug_referee_if.sv
// -----------------------------------------------------------------------------
// tug_referee_if
// Signal bundle between the tug-of-war referee and its surroundings.
//
// Signal semantics (single contract for all signals in this bundle):
//   pull_l / pull_r are one-cycle pulses from the edge detectors. They carry
//   no valid/ready pairing: a pulse is consumed on the rising edge at which it
//   is high, or it is lost. The referee applies backpressure only through
//   `stop`. Upstream gates pulls combinationally on it, so anything that
//   arrives while stop=1 is discarded. `start` is sampled only in OVER.
//   All outputs are registered and change one cycle after the sampling edge.
//
// Modports:
//   master : drives pull_l, pull_r, start; observes the referee outputs
//   slave  : the referee itself
// -----------------------------------------------------------------------------
interface tug_referee_if #(
    parameter int NLIGHTS = 9,
    parameter int SCORE_W = 3
);
    logic               pull_l;
    logic               pull_r;
    logic               start;
    logic [NLIGHTS-1:0] lights;
    logic               stop;
    logic               round_done;
    logic               winner_l;
    logic               winner_r;
    logic [SCORE_W-1:0] score_l;
    logic [SCORE_W-1:0] score_r;

    modport master (
        output pull_l, pull_r, start,
        input  lights, stop, round_done, winner_l, winner_r, score_l, score_r
    );

    modport slave (
        input  pull_l, pull_r, start,
        output lights, stop, round_done, winner_l, winner_r, score_l, score_r
    );
endinterface

// File: rtl/tug_referee.sv
// -----------------------------------------------------------------------------
// tug_referee
// Match controller for the two-player tug-of-war game. It arbitrates the
// left/right pull pulses, moves a one-hot marker along the light bar, detects
// round wins, keeps the scores and sequences rounds until a match is won.
//
// Ports:
//   clk_i   : system clock, rising edge
//   rst_ni  : synchronous active-low reset
//   bus     : tug_referee_if.slave (pulls/start in; lights, stop, round_done,
//             winner flags and scores out)
//   state_o : current FSM state (0=PLAY, 1=HOLD, 2=OVER) for observation
// -----------------------------------------------------------------------------
module tug_referee #(
    parameter int NLIGHTS     = 9,
    parameter int HOLD_CYCLES = 8,
    parameter int WIN_SCORE   = 7,
    parameter int SCORE_W     = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    tug_referee_if.slave    bus,
    output logic [1:0]      state_o
);

    localparam int PW = $clog2(NLIGHTS);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [PW-1:0]      POS_C     = PW'((NLIGHTS - 1) / 2);
    localparam logic [PW-1:0]      POS_MAX   = PW'(NLIGHTS - 1);
    localparam logic [HW-1:0]      HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);
    localparam logic [NLIGHTS-1:0] ONE_HOT_0 = NLIGHTS'(1);

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        HOLD = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      pos_q, pos_d;
    logic [NLIGHTS-1:0] lights_q, lights_d;
    logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;
    logic               winner_l_q, winner_l_d;
    logic               winner_r_q, winner_r_d;
    logic               stop_q, stop_d;
    logic               round_done_q, round_done_d;

    // Exactly one player pulling; simultaneous pulls cancel.
    logic pull_l_only, pull_r_only;
    assign pull_l_only = bus.pull_l & ~bus.pull_r;
    assign pull_r_only = bus.pull_r & ~bus.pull_l;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= PLAY;
            pos_q        <= POS_C;
            lights_q     <= ONE_HOT_0 << POS_C;
            hold_cnt_q   <= '0;
            score_l_q    <= '0;
            score_r_q    <= '0;
            winner_l_q   <= 1'b0;
            winner_r_q   <= 1'b0;
            stop_q       <= 1'b0;
            round_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            lights_q     <= lights_d;
            hold_cnt_q   <= hold_cnt_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            winner_l_q   <= winner_l_d;
            winner_r_q   <= winner_r_d;
            stop_q       <= stop_d;
            round_done_q <= round_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        hold_cnt_d   = hold_cnt_q;
        score_l_d    = score_l_q;
        score_r_d    = score_r_q;
        winner_l_d   = winner_l_q;
        winner_r_d   = winner_r_q;
        stop_d       = stop_q;
        round_done_d = 1'b0;

        unique case (state_q)
            PLAY: begin
                if (pull_l_only) begin
                    if (pos_q != POS_MAX) begin
                        pos_d = pos_q + 1'b1;
                    end else begin
                        // Marker stays on the edge light while the round resolves.
                        score_l_d    = score_l_q + 1'b1;
                        winner_l_d   = 1'b1;
                        winner_r_d   = 1'b0;
                        round_done_d = 1'b1;
                        stop_d       = 1'b1;
                        hold_cnt_d   = '0;
                        state_d      = (score_l_d == SCORE_WIN) ? OVER : HOLD;
                    end
                end else if (pull_r_only) begin
                    if (pos_q != '0) begin
                        pos_d = pos_q - 1'b1;
                    end else begin
                        score_r_d    = score_r_q + 1'b1;
                        winner_l_d   = 1'b0;
                        winner_r_d   = 1'b1;
                        round_done_d = 1'b1;
                        stop_d       = 1'b1;
                        hold_cnt_d   = '0;
                        state_d      = (score_r_d == SCORE_WIN) ? OVER : HOLD;
                    end
                end
            end

            HOLD: begin
                // Counter runs 0..HOLD_CYCLES-1, giving exactly HOLD_CYCLES cycles here.
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = PLAY;
                    pos_d      = POS_C;
                    stop_d     = 1'b0;
                    winner_l_d = 1'b0;
                    winner_r_d = 1'b0;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            OVER: begin
                if (bus.start) begin
                    state_d    = PLAY;
                    pos_d      = POS_C;
                    stop_d     = 1'b0;
                    score_l_d  = '0;
                    score_r_d  = '0;
                    winner_l_d = 1'b0;
                    winner_r_d = 1'b0;
                end
            end

            default: begin
                state_d = PLAY;
                pos_d   = POS_C;
                stop_d  = 1'b0;
            end
        endcase

        lights_d = ONE_HOT_0 << pos_d;
    end

    assign bus.lights     = lights_q;
    assign bus.stop       = stop_q;
    assign bus.round_done = round_done_q;
    assign bus.winner_l   = winner_l_q;
    assign bus.winner_r   = winner_r_q;
    assign bus.score_l    = score_l_q;
    assign bus.score_r    = score_r_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_tug_referee.sv
// -----------------------------------------------------------------------------
// tb_tug_referee
// Directed bench for tug_referee with NLIGHTS=9, HOLD_CYCLES=8, WIN_SCORE=7,
// SCORE_W=3. Inputs change 1 time unit after a rising edge; outputs are
// checked at that same point, after the registers have settled.
// -----------------------------------------------------------------------------
module tb_tug_referee;

    logic       clk;
    logic       rst_n;
    logic [1:0] state;
    int         checks;
    int         errors;

    localparam logic [8:0] L_CENTER = 9'b000010000;
    localparam logic [8:0] L_LEFT   = 9'b100000000;
    localparam logic [8:0] L_RIGHT  = 9'b000000001;

    tug_referee_if #(.NLIGHTS(9), .SCORE_W(3)) bus ();

    tug_referee #(
        .NLIGHTS    (9),
        .HOLD_CYCLES(8),
        .WIN_SCORE  (7),
        .SCORE_W    (3)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave),
        .state_o(state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard helpers
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [8:0] lights, input logic stop,
                           input logic [2:0] sl, input logic [2:0] sr,
                           input logic wl, input logic wr, input logic rd,
                           input logic [1:0] st);
        chk({tag, ".lights"}, 32'(bus.lights), 32'(lights));
        chk({tag, ".stop"}, 32'(bus.stop), 32'(stop));
        chk({tag, ".score_l"}, 32'(bus.score_l), 32'(sl));
        chk({tag, ".score_r"}, 32'(bus.score_r), 32'(sr));
        chk({tag, ".winner_l"}, 32'(bus.winner_l), 32'(wl));
        chk({tag, ".winner_r"}, 32'(bus.winner_r), 32'(wr));
        chk({tag, ".round_done"}, 32'(bus.round_done), 32'(rd));
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".onehot"}, 32'($onehot(bus.lights)), 32'd1);
    endtask

    // driver: apply inputs for exactly one rising edge, then return them to idle
    task automatic cyc(input logic pl, input logic pr, input logic st, input logic rn);
        bus.pull_l = pl;
        bus.pull_r = pr;
        bus.start  = st;
        rst_n      = rn;
        @(posedge clk);
        #1;
        bus.pull_l = 1'b0;
        bus.pull_r = 1'b0;
        bus.start  = 1'b0;
        rst_n      = 1'b1;
    endtask

    task automatic pulls(input int n, input logic pl, input logic pr);
        for (int i = 0; i < n; i++) cyc(pl, pr, 1'b0, 1'b1);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        bus.pull_l = 1'b0;
        bus.pull_r = 1'b0;
        bus.start  = 1'b0;
        rst_n      = 1'b0;

        // reset held for two edges, then released
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk_all("reset", L_CENTER, 0, 0, 0, 0, 0, 0, 2'd0);
        pulls(1, 0, 0);
        chk_all("reset_rel", L_CENTER, 0, 0, 0, 0, 0, 0, 2'd0);

        // marker movement and cancelling pulls
        cyc(1, 0, 0, 1); chk("mv_l1", 32'(bus.lights), 32'(9'b000100000));
        cyc(1, 0, 0, 1); chk("mv_l2", 32'(bus.lights), 32'(9'b001000000));
        cyc(1, 0, 0, 1); chk("mv_l3", 32'(bus.lights), 32'(9'b010000000));
        cyc(0, 1, 0, 1); chk("mv_r1", 32'(bus.lights), 32'(9'b001000000));
        cyc(1, 1, 0, 1); chk("mv_both", 32'(bus.lights), 32'(9'b001000000));

        // start is ignored in PLAY
        cyc(0, 0, 1, 1);
        chk_all("start_play", 9'b001000000, 0, 0, 0, 0, 0, 0, 2'd0);
        pulls(2, 0, 1);
        chk("recenter", 32'(bus.lights), 32'(L_CENTER));

        // left walks to the edge and wins a round
        pulls(4, 1, 0);
        chk_all("edge_l", L_LEFT, 0, 0, 0, 0, 0, 0, 2'd0);
        cyc(1, 0, 0, 1);
        chk_all("win_l", L_LEFT, 1, 1, 0, 1, 0, 1, 2'd1);

        // seven HOLD cycles with pulls (and one start) that must be ignored
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, i[0], (i == 2), 1'b1);
            chk_all("hold", L_LEFT, 1, 1, 0, 1, 0, 0, 2'd1);
        end
        cyc(1, 0, 0, 1);
        chk_all("hold_exit", L_CENTER, 0, 1, 0, 0, 0, 0, 2'd0);

        // simultaneous pulls at the edge light cancel
        pulls(4, 1, 0);
        cyc(1, 1, 0, 1);
        chk_all("both_edge", L_LEFT, 0, 1, 0, 0, 0, 0, 2'd0);
        cyc(1, 1, 0, 1);
        chk_all("both_edge2", L_LEFT, 0, 1, 0, 0, 0, 0, 2'd0);
        cyc(1, 0, 0, 1);
        chk_all("win_l2", L_LEFT, 1, 2, 0, 1, 0, 1, 2'd1);
        pulls(8, 0, 0);

        // right wins twice, flags switch sides
        pulls(5, 0, 1);
        chk_all("win_r1", L_RIGHT, 1, 2, 1, 0, 1, 1, 2'd1);
        pulls(8, 0, 0);
        pulls(5, 0, 1);
        pulls(8, 0, 0);

        // left wins four more: 6/2 in PLAY
        for (int k = 0; k < 4; k++) begin
            pulls(5, 1, 0);
            pulls(8, 0, 0);
        end
        chk_all("score_6_2", L_CENTER, 0, 6, 2, 0, 0, 0, 2'd0);
        cyc(0, 0, 0, 0);
        chk_all("rst_play", L_CENTER, 0, 0, 0, 0, 0, 0, 2'd0);

        // reset in the middle of HOLD
        pulls(5, 1, 0);
        chk_all("win_pre_rst", L_LEFT, 1, 1, 0, 1, 0, 1, 2'd1);
        pulls(3, 0, 0);
        cyc(1, 0, 0, 0);
        chk_all("rst_hold", L_CENTER, 0, 0, 0, 0, 0, 0, 2'd0);
        cyc(1, 0, 0, 1);
        chk("play_after_rst", 32'(bus.lights), 32'(9'b000100000));
        cyc(0, 1, 0, 1);

        // right takes the match 7-0
        for (int k = 1; k <= 6; k++) begin
            pulls(5, 0, 1);
            chk("match_score_r", 32'(bus.score_r), 32'(k));
            pulls(8, 0, 0);
        end
        pulls(5, 0, 1);
        chk_all("match_r", L_RIGHT, 1, 0, 7, 0, 1, 1, 2'd2);
        pulls(1, 0, 0);
        chk_all("over_idle", L_RIGHT, 1, 0, 7, 0, 1, 0, 2'd2);
        for (int i = 0; i < 20; i++) cyc(i[0], ~i[0], 1'b0, 1'b1);
        chk_all("over_pulls", L_RIGHT, 1, 0, 7, 0, 1, 0, 2'd2);

        // start begins a fresh match
        cyc(0, 0, 1, 1);
        chk_all("restart", L_CENTER, 0, 0, 0, 0, 0, 0, 2'd0);
        cyc(1, 0, 0, 1);
        chk("play_after_start", 32'(bus.lights), 32'(9'b000100000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // watchdog
    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tug_referee.md
Name: tug_referee

Overview:
- Match controller for the two-player tug-of-war game.
- Consumes the one-cycle pull pulses from the left and right player edge-detector blocks, arbitrates them, and moves the rope marker across a one-hot light bar.
- Detects round wins, keeps per-player scores and sequences rounds until a match winner exists.
- Drives the shared stop line back to both edge-detector blocks so that no pulls are generated while a round is being resolved.

Parameters:
- NLIGHTS, 9: light-bar length. Must be odd and >= 3. Center index C = (NLIGHTS-1)/2.
- HOLD_CYCLES, 8: cycles spent in HOLD after a round win before re-centering. Must be >= 1.
- WIN_SCORE, 7: round wins needed to take the match. Must be >= 1 and <= 2^SCORE_W-1.
- SCORE_W, 3: width of each score counter.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-low reset; Reset=0 at a rising edge resets the block.
- pull_l  input  1  one-cycle pull pulse from the left player.
- pull_r  input  1  one-cycle pull pulse from the right player.
- start  input  1  level/pulse; begins a new match when the block is in OVER.
- lights  output  NLIGHTS  one-hot marker position; bit NLIGHTS-1 is the leftmost light.
- stop  output  1  registered; 1 in HOLD and OVER, 0 in PLAY.
- round_done  output  1  one-cycle pulse on the cycle HOLD is entered.
- winner_l  output  1  registered; 1 while the left player holds the last round or match win.
- winner_r  output  1  registered; 1 while the right player holds the last round or match win.
- score_l  output  SCORE_W  left player's round wins.
- score_r  output  SCORE_W  right player's round wins.

Behaviour:
- Reset (Reset=0 at an edge):
  - state=PLAY, pos=C, lights=one-hot(C).
  - score_l=score_r=0; winner_l=winner_r=0; stop=0; round_done=0; hold counter=0.
  - Reset has priority over every other input in every state, including mid-HOLD.
- All outputs are registered. An effect is visible the cycle after the sampling edge (1-cycle latency).
- PLAY, pulls sampled each edge:
  - pull_l & ~pull_r: if pos<NLIGHTS-1 then pos+1; if pos==NLIGHTS-1 the left player wins the round.
  - pull_r & ~pull_l: if pos>0 then pos-1; if pos==0 the right player wins the round.
  - Both pulls or neither: no change. Simultaneous pulls cancel, including at the edges.
- Round win, on the same edge:
  - Winner's score increments; winner_x=1; the other winner flag is 0.
  - round_done=1 for exactly one cycle; stop=1; pos is unchanged, so the marker stays on the edge light.
  - If the new score == WIN_SCORE, go to OVER; otherwise go to HOLD with hold counter=0.
- HOLD:
  - Pulls are ignored; stop=1.
  - The counter increments every cycle. When the counter reaches HOLD_CYCLES-1, the next state is PLAY with pos=C, stop=0 and both winner flags=0.
  - Total HOLD duration is exactly HOLD_CYCLES cycles.
- OVER:
  - Pulls are ignored; stop=1; the winner flag and scores hold.
  - start=1 at an edge goes to PLAY with scores=0, winner flags=0, pos=C, stop=0.
  - start is ignored in PLAY and HOLD.
- Scores never exceed WIN_SCORE, so no wrap-around is possible.
- Pulls arriving in the same cycle that stop rises are already lost. Upstream blocks gate on stop combinationally, so pulls seen here during HOLD/OVER are discarded by design.
- Invariants:
  - lights is always exactly one-hot.
  - winner_l & winner_r is never 1.
  - round_done is never high for 2 consecutive cycles.

Test Plan (NLIGHTS=9, HOLD_CYCLES=8, WIN_SCORE=7, SCORE_W=3):
1. Reset held at 0 for 2 cycles, then released:
   - lights=9'b000010000, stop=0, scores 0/0, round_done=0.
2. 3 pull_l pulses, then 1 pull_r pulse, then 1 cycle with pull_l=pull_r=1:
   - lights go 000100000, 001000000, 010000000, 001000000, then stay at 001000000.
3. From center, 5 pull_l pulses:
   - The 4th reaches 100000000.
   - The 5th gives score_l=1, winner_l=1, stop=1 and a round_done pulse, with lights still 100000000.
   - Pulls during the next 8 cycles are ignored.
   - Then lights=000010000, stop=0, winner_l=0.
4. Right player wins 7 rounds via pull_r pulses:
   - After the 7th win: score_r=7, winner_r=1, stop=1, state OVER.
   - 20 further pulls produce no change.
   - start=1 gives scores 0/0, winner_r=0, lights=000010000, stop=0.
5. Reset driven to 0 at HOLD cycle 3, and again at score 6/2 in PLAY:
   - Both cases give the full reset state from item 1 on the next cycle.
6. At pos=8, pull_l=pull_r=1 in the same cycle:
   - No win, no score change, pos stays 8.
